// File: rtl/timer_pkg.sv
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared constants and FSM state type for the timer_counter block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  // Word-register selectors, taken from Addr_In[3:2]
  localparam logic [1:0] c_reg_ctrl   = 2'd0;
  localparam logic [1:0] c_reg_preset = 2'd1;
  localparam logic [1:0] c_reg_count  = 2'd2;

  localparam int c_ctrl_en      = 0;
  localparam int c_ctrl_mode_lo = 1;
  localparam int c_ctrl_mode_hi = 2;
  localparam int c_ctrl_im      = 3;

  localparam logic [1:0] c_mode_oneshot = 2'b00;
  localparam logic [1:0] c_mode_reload  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_t;

endpackage

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
// Module   : timer_counter
// Brief    : Memory-mapped 32-bit down-counting timer with maskable IRQ.
//            Define TIMER_AUTORELOAD_EN to enable MODE 01 auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_counter
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Addr_In,
  input  logic        WE,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        IRQ
);

  logic [3:0]   r_ctrl;
  logic [31:0]  r_preset;
  logic [31:0]  r_count;
  logic         r_irq_flag;
  timer_state_t r_state;

  logic [1:0]   w_reg_sel;
  logic         w_ctrl_wr;
  logic         w_preset_wr;
  logic         w_en;
  logic [1:0]   w_mode_eff;
  logic         w_addr_lo_unused;

  assign w_reg_sel        = Addr_In[3:2];
  assign w_addr_lo_unused = ^Addr_In[1:0];
  assign w_ctrl_wr        = WE && (w_reg_sel == c_reg_ctrl);
  assign w_preset_wr      = WE && (w_reg_sel == c_reg_preset);
  assign w_en             = r_ctrl[c_ctrl_en];

`ifdef TIMER_AUTORELOAD_EN
  assign w_mode_eff = (r_ctrl[c_ctrl_mode_hi:c_ctrl_mode_lo] == c_mode_reload)
                      ? c_mode_reload : c_mode_oneshot;
`else
  assign w_mode_eff = c_mode_oneshot;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
      r_state    <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_en) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!w_en) begin
            r_state <= ST_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            r_count    <= 32'd0;
            r_irq_flag <= 1'b1;
            r_state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (w_mode_eff == c_mode_reload) r_irq_flag <= 1'b0;
          else                             r_ctrl[c_ctrl_en] <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Bus writes come last so a CTRL write overrides the FSM's EN clear
      if (w_ctrl_wr) begin
        r_ctrl     <= Data_In[3:0];
        r_irq_flag <= 1'b0;
      end
      if (w_preset_wr) r_preset <= Data_In;
    end
  end

  always_comb begin
    Data_Out = 32'd0;
    case (w_reg_sel)
      c_reg_ctrl:   Data_Out = {28'd0, r_ctrl};
      c_reg_preset: Data_Out = r_preset;
      c_reg_count:  Data_Out = r_count;
      default:      Data_Out = 32'd0;
    endcase
  end

  assign IRQ = r_ctrl[c_ctrl_im] & r_irq_flag;

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
// ============================================================================
// Module   : tb_timer_counter
// Brief    : Randomized self-checking bench for timer_counter against a
//            timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Addr_In;
  logic        WE;
  logic [31:0] Data_In;
  logic [31:0] Data_Out;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  timer_counter dut (
    .clk      (clk),
    .reset    (reset),
    .Addr_In  (Addr_In),
    .WE       (WE),
    .Data_In  (Data_In),
    .Data_Out (Data_Out),
    .IRQ      (IRQ)
  );

  always #10 clk = ~clk;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit c_model_reload = 1'b1;
`else
  localparam bit c_model_reload = 1'b0;
`endif

  // Model: a run is tracked by its age in edges since the timer left idle.
  // Age 0 is the load edge pending; at age a>=1 the count is load-(a-1),
  // and the interrupt lands at age 1+max(load,1).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic [31:0] m_load;
  logic        m_flag;
  int          m_age;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl   = 4'd0;
    m_preset = 32'd0;
    m_count  = 32'd0;
    m_load   = 32'd0;
    m_flag   = 1'b0;
    m_age    = -1;
  endtask

  task automatic model_edge(input logic we, input logic [3:0] addr, input logic [31:0] din);
    longint irq_age;
    irq_age = 1 + ((m_load == 0) ? 1 : longint'(m_load));
    if (m_age < 0) begin
      if (m_ctrl[0]) m_age = 0;
    end else if (m_age == 0) begin
      m_load  = m_preset;
      m_count = m_preset;
      m_age   = 1;
    end else if (m_age < irq_age) begin
      if (!m_ctrl[0]) begin
        m_age = -1;
      end else begin
        m_age++;
        if (m_age >= irq_age) begin
          m_count = 32'd0;
          m_flag  = 1'b1;
        end else begin
          m_count = 32'(longint'(m_load) - longint'(m_age - 1));
        end
      end
    end else begin
      if (c_model_reload && m_ctrl[2:1] == 2'b01) m_flag = 1'b0;
      else                                       m_ctrl[0] = 1'b0;
      m_age = -1;
    end
    if (we && addr[3:2] == 2'd0) begin
      m_ctrl = din[3:0];
      m_flag = 1'b0;
    end
    if (we && addr[3:2] == 2'd1) m_preset = din;
  endtask

  task automatic verify();
    logic [31:0] exp;
    string       tags [4] = '{"ctrl", "preset", "count", "unmapped"};
    for (int a = 0; a < 4; a++) begin
      Addr_In = 4'(a * 4 + int'($urandom_range(0, 3)));
      #1;
      case (a)
        0:       exp = {28'd0, m_ctrl};
        1:       exp = m_preset;
        2:       exp = m_count;
        default: exp = 32'd0;
      endcase
      check(tags[a], Data_Out, exp);
    end
    check("irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [3:0] addr,
                       input logic [31:0] din);
    @(negedge clk);
    reset   = rst;
    WE      = we;
    Addr_In = addr;
    Data_In = din;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(we, addr, din);
    #1;
    WE    = 1'b0;
    reset = 1'b0;
    verify();
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] din);
    cycle(1'b0, 1'b1, addr, din);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'(($urandom_range(0, 3)) * 4), $urandom);
  endtask

  initial begin
    reset   = 1'b1;
    WE      = 1'b0;
    Addr_In = 4'd0;
    Data_In = 32'd0;
    model_reset();
    cycle(1'b1, 1'b0, 4'h0, 32'd0);
    cycle(1'b1, 1'b0, 4'h0, 32'd0);

    // One-shot with IRQ enabled, then disable
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h9);
    idle(10);
    wr(4'h0, 32'hA);
    idle(3);

    // Auto-reload request, paused mid-count and restarted
    wr(4'h0, 32'hB);
    idle(25);
    wr(4'h0, 32'h8);
    idle(4);
    wr(4'h0, 32'hB);
    idle(12);

    // Masked interrupt, then CTRL write clears the pending flag
    wr(4'h4, 32'd3);
    wr(4'h0, 32'h1);
    idle(8);
    wr(4'h0, 32'h8);
    idle(3);

    // COUNT is read-only; PRESET=0 edge case
    wr(4'h8, 32'h1234_5678);
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h9);
    idle(6);

    // Randomized traffic, including reset mid-count
    for (int i = 0; i < 800; i++) begin
      logic        rst;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] din;
      rst  = ($urandom_range(0, 99) == 0);
      we   = ($urandom_range(0, 5) == 0);
      addr = 4'($urandom);
      din  = $urandom;
      if (addr[3:2] == 2'd1 && $urandom_range(0, 7) != 0) din = 32'($urandom_range(0, 9));
      cycle(rst, we, addr, din);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
